// File: rtl/clint_arb.sv
// -----------------------------------------------------------------------------
// clint_arb
// Two-master arbiter in front of a single CLINT slave. Master 0 is the core,
// master 1 is the debug module. The write and read channels are arbitrated
// independently, each with its own 1-bit round-robin pointer.
//
// Ports
//   clk, resetb               clock, asynchronous active-low reset
//   mN_wready                 write request from master N
//   mN_waddr/wdata/wstrb      write address / data / byte strobes
//   mN_wvalid                 write accepted (one-cycle pulse)
//   mN_rready, mN_raddr       read request and address
//   mN_rvalid                 read response (one-cycle pulse)
//   mN_rresp, mN_rdata        response error flag and data (0 when no rvalid)
//   s_wready/waddr/wdata/wstrb  write request towards the slave
//   s_wvalid                  write completion from the slave
//   s_rready/raddr            read request towards the slave (one-cycle pulse)
//   s_rvalid/rresp/rdata      read response from the slave
// -----------------------------------------------------------------------------
module clint_arb #(
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetb,
  // master 0 (core)
  input  logic        m0_wready,
  output logic        m0_wvalid,
  input  logic [31:0] m0_waddr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_rready,
  input  logic [31:0] m0_raddr,
  output logic        m0_rvalid,
  output logic        m0_rresp,
  output logic [31:0] m0_rdata,
  // master 1 (debug)
  input  logic        m1_wready,
  output logic        m1_wvalid,
  input  logic [31:0] m1_waddr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_rready,
  input  logic [31:0] m1_raddr,
  output logic        m1_rvalid,
  output logic        m1_rresp,
  output logic [31:0] m1_rdata,
  // clint slave
  output logic        s_wready,
  output logic [31:0] s_waddr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_rready,
  output logic [31:0] s_raddr,
  input  logic        s_rvalid,
  input  logic        s_rresp,
  input  logic [31:0] s_rdata
);

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rstate_t;

  // Last counter value of the wait window; the error response fires here.
  localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 32'd1);

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic       wptr_r;
  logic       wlock_r;
  logic       wlock_owner_r;
  logic [1:0] wreq_s;
  logic       wgrant_s;
  logic       wgo_s;

  assign wreq_s = {m1_wready, m0_wready};

  // Write grant: a stalled write keeps its master, otherwise round-robin.
  always_comb begin
    wgrant_s = 1'b0;
    if (wlock_r) begin
      wgrant_s = wlock_owner_r;
    end else if (wreq_s[wptr_r]) begin
      wgrant_s = wptr_r;
    end else begin
      wgrant_s = ~wptr_r;
    end
  end

  // A grant is only real while the granted master is actually requesting;
  // resetb gating keeps every output at 0 during reset.
  assign wgo_s = resetb & wreq_s[wgrant_s];

  // Write-side outputs mirror the granted master in the same cycle.
  always_comb begin
    s_wready  = wgo_s;
    s_waddr   = 32'd0;
    s_wdata   = 32'd0;
    s_wstrb   = 4'd0;
    m0_wvalid = wgo_s & s_wvalid & ~wgrant_s;
    m1_wvalid = wgo_s & s_wvalid & wgrant_s;
    if (wgo_s && wgrant_s) begin
      s_waddr = m1_waddr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end else if (wgo_s) begin
      s_waddr = m0_waddr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else begin
      s_waddr = 32'd0;
      s_wdata = 32'd0;
      s_wstrb = 4'd0;
    end
  end

  // Write pointer and lock: completion rotates priority, a stall locks grant.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wptr_r        <= 1'b0;
      wlock_r       <= 1'b0;
      wlock_owner_r <= 1'b0;
    end else if (wgo_s && s_wvalid) begin
      wptr_r  <= ~wgrant_s;
      wlock_r <= 1'b0;
    end else if (wgo_s) begin
      wlock_r       <= 1'b1;
      wlock_owner_r <= wgrant_s;
    end else begin
      wptr_r        <= wptr_r;
      wlock_r       <= wlock_r;
      wlock_owner_r <= wlock_owner_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rstate_t    rstate_r, rstate_nx_s;
  logic       rowner_r, rowner_nx_s;
  logic [7:0] rcnt_r, rcnt_nx_s;
  logic       rptr_r, rptr_nx_s;
  logic [1:0] rreq_s;
  logic       rsel_s;
  logic       rissue_s;
  logic       rok_s;
  logic       rtmo_s;
  logic       rdone_s;
  logic       rresp_s;
  logic [31:0] rdata_s;

  assign rreq_s   = {m1_rready, m0_rready};
  assign rsel_s   = rreq_s[rptr_r] ? rptr_r : ~rptr_r;
  assign rissue_s = resetb & (rstate_r == R_IDLE) & (|rreq_s);
  assign rok_s    = (rstate_r == R_WAIT) & s_rvalid;
  // A real response in the last window cycle wins over the timeout.
  assign rtmo_s   = (rstate_r == R_WAIT) & ~s_rvalid & (rcnt_r == TMO_LAST);
  assign rdone_s  = resetb & (rok_s | rtmo_s);
  assign rdata_s  = rok_s ? s_rdata : 32'd0;
  assign rresp_s  = rok_s ? s_rresp : 1'b1;

  // Read FSM next state; s_rvalid in R_IDLE falls through untouched.
  always_comb begin
    rstate_nx_s = rstate_r;
    rowner_nx_s = rowner_r;
    rcnt_nx_s   = rcnt_r;
    rptr_nx_s   = rptr_r;
    case (rstate_r)
      R_IDLE: begin
        if (rissue_s) begin
          rstate_nx_s = R_WAIT;
          rowner_nx_s = rsel_s;
          rcnt_nx_s   = 8'd0;
        end else begin
          rstate_nx_s = R_IDLE;
        end
      end
      R_WAIT: begin
        if (rok_s || rtmo_s) begin
          rstate_nx_s = R_IDLE;
          rptr_nx_s   = ~rowner_r;
        end else begin
          rcnt_nx_s = rcnt_r + 8'd1;
        end
      end
      default: begin
        rstate_nx_s = R_IDLE;
      end
    endcase
  end

  // Read FSM state, owner, timeout counter and pointer registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rstate_r <= R_IDLE;
      rowner_r <= 1'b0;
      rcnt_r   <= 8'd0;
      rptr_r   <= 1'b0;
    end else begin
      rstate_r <= rstate_nx_s;
      rowner_r <= rowner_nx_s;
      rcnt_r   <= rcnt_nx_s;
      rptr_r   <= rptr_nx_s;
    end
  end

  // Read-side outputs: one-cycle slave request and owner response pulse.
  always_comb begin
    s_rready  = rissue_s;
    s_raddr   = 32'd0;
    m0_rvalid = rdone_s & ~rowner_r;
    m1_rvalid = rdone_s & rowner_r;
    m0_rdata  = 32'd0;
    m0_rresp  = 1'b0;
    m1_rdata  = 32'd0;
    m1_rresp  = 1'b0;
    if (rissue_s) begin
      s_raddr = rsel_s ? m1_raddr : m0_raddr;
    end else begin
      s_raddr = 32'd0;
    end
    if (m0_rvalid) begin
      m0_rdata = rdata_s;
      m0_rresp = rresp_s;
    end else if (m1_rvalid) begin
      m1_rdata = rdata_s;
      m1_rresp = rresp_s;
    end else begin
      m0_rdata = 32'd0;
      m1_rdata = 32'd0;
    end
  end

endmodule

// File: doc/clint_arb.md
CLINT_ARB -- requirements
Module: clint_arb

Interface
REQ-001 Parameter RD_TIMEOUT, default 16, is the number of R_WAIT cycles without s_rvalid before an error response is generated; legal range 2..255.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 resetb  input  1  reset, asynchronous and active-low.
REQ-004 mN_wready  input  1  write request from master N (N = 0 core, 1 debug).
REQ-005 mN_wvalid  output  1  write accepted, one-cycle pulse.
REQ-006 mN_waddr / mN_wdata  input  32  write address / data.
REQ-007 mN_wstrb  input  4  byte strobes.
REQ-008 mN_rready  input  1  read request.
REQ-009 mN_raddr  input  32  read address.
REQ-010 mN_rvalid  output  1  read response, one-cycle pulse.
REQ-011 mN_rresp  output  1  response error flag.
REQ-012 mN_rdata  output  32  read data.
REQ-013 s_wready, s_waddr, s_wdata, s_wstrb, s_rready, s_raddr  output  1/32/32/4/1/32  to the clint slave.
REQ-014 s_wvalid, s_rvalid, s_rresp, s_rdata  input  1/1/1/32  from the clint slave.

Function
REQ-015 A master SHALL hold its request and request fields stable until it receives the matching wvalid or rvalid; the arbiter does not check this.
REQ-016 Write and read channels SHALL arbitrate independently.
REQ-017 Each channel SHALL use round-robin priority with its own 1-bit pointer; reset value 0 (m0 first).
REQ-018 Write grant selection:
- When no write is locked, the grant SHALL be chosen combinationally in the cycle requests are seen: pointer master if requesting, otherwise the other.
- s_wready, s_waddr, s_wdata and s_wstrb SHALL mirror the granted master in that same cycle.
REQ-019 If s_wready=1 and s_wvalid=0, the grant SHALL lock to that master until s_wvalid=1.
REQ-020 mN_wvalid SHALL equal s_wvalid AND (grant==N); the ungranted master sees 0.
REQ-021 On a completed write (s_wready and s_wvalid both 1), the write pointer SHALL move to the other master and the lock SHALL clear.
REQ-022 The read FSM SHALL have states R_IDLE and R_WAIT, plus an owner register and an 8-bit timeout counter.
REQ-023 In R_IDLE with any mN_rready=1:
- The arbiter SHALL select the owner by the read pointer.
- It SHALL drive s_rready=1 and s_raddr for exactly that one cycle.
- It SHALL capture the owner, clear the counter and enter R_WAIT.
REQ-024 In R_WAIT, s_rready SHALL be 0, and further read requests SHALL stall.
REQ-025 In R_WAIT with s_rvalid=1, the arbiter SHALL:
- pulse mOwner_rvalid for one cycle, with rdata=s_rdata and rresp=s_rresp;
- flip the read pointer to the non-owner;
- return to R_IDLE.
REQ-026 In R_WAIT with s_rvalid=0, the counter SHALL increment.
REQ-027 When the counter equals RD_TIMEOUT-1 and s_rvalid=0, the arbiter SHALL:
- pulse mOwner_rvalid with rresp=1 and rdata=0;
- flip the pointer;
- return to R_IDLE.
REQ-028 If s_rvalid arrives in the timeout cycle, the real response SHALL win.
REQ-029 An s_rvalid seen in R_IDLE (a late stray response) SHALL be discarded: no mN_rvalid, no state change.
REQ-030 When mN_rvalid=0, mN_rdata and mN_rresp SHALL be 0.
REQ-031 A write and a read SHALL be able to issue in the same cycle from different or the same master.

Reset
REQ-032 While resetb=0, all outputs SHALL be 0.
REQ-033 While resetb=0, the following SHALL be forced: read FSM to R_IDLE, both pointers to 0, write lock clear, owner 0, counter 0.
REQ-034 A read in flight at reset assertion SHALL be abandoned; a post-reset s_rvalid is discarded per REQ-029.
REQ-035 The first arbitration after resetb rises SHALL favour m0.

Verification
REQ-036 Both masters request a write in cycle 0 with s_wvalid tied 1 -> m0 granted in cycle 0, m1 in cycle 1, s_waddr follows m0 then m1, each master sees one wvalid pulse.
REQ-037 m1 writes 0x0200_4000 with s_wvalid held 0 for 3 cycles while m0 also requests -> grant stays m1 for 4 cycles, then m0 is served.
REQ-038 m0 reads 0x0200_BFF8, slave returns rdata 0x1234_5678 two cycles after issue -> s_rready high for one cycle only, m0_rvalid with 0x1234_5678 and rresp=0, m1 sees nothing.
REQ-039 m1 reads with the slave silent and RD_TIMEOUT=16 -> m1_rvalid=1, rresp=1, rdata=0 in the 16th R_WAIT cycle; a later stray s_rvalid is dropped.
REQ-040 resetb pulsed low during R_WAIT -> all outputs 0 immediately; after release an m0+m1 read grants m0 first.
REQ-041 Write and read both issued in one cycle by m0 -> both complete correctly with no interaction between channels.
